core_ctrl: RTL and testbench
============================

# core_ctrl

Multi-cycle sequencing controller for the RV32I core. It sits between the instruction decoder and the datapath. It consumes the decoder's `op` and `unknown_instr` outputs plus the ALU branch comparison, and drives every datapath enable and mux select through a fetch/decode/execute/memory/writeback state machine. Memory accesses use a valid/ready handshake with a bus timeout, and illegal instructions or bus timeouts park the core in a sticky trap state.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of cycles `mem_req` may wait for `mem_ready`; legal range is ≥2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  7  opcode from the decoder, instr[6:0]; stable from DECODE through retire.
- `unknown_instr`  in  1  decoder flag for an unsupported opcode.
- `branch_taken`  in  1  ALU comparison result; valid in EXEC.
- `mem_ready`  in  1  memory accepts/completes the current request this cycle.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  request is a store.
- `mem_is_fetch`  out  1  address mux select: 1 = PC, 0 = ALU result.
- `ir_we`  out  1  instruction register load enable.
- `pc_we`  out  1  PC write enable.
- `pc_src`  out  2  PC source: 00 = PC+4, 01 = PC+imm, 10 = ALU result & ~1.
- `rf_we`  out  1  register-file write enable.
- `wb_sel`  out  2  writeback source: 00 = ALU, 01 = load data, 10 = PC+4, 11 = imm.
- `alu_a_sel`  out  1  ALU A operand: 0 = rs1, 1 = PC.
- `alu_b_sel`  out  1  ALU B operand: 0 = rs2, 1 = imm.
- `trap`  out  1  sticky trap indication.
- `trap_cause`  out  2  trap cause: 01 = illegal instruction, 10 = bus timeout, 00 = none.
- `instret`  out  1  one-cycle pulse per retired instruction.
- `state`  out  3  current state, for debug.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- Outputs are combinational functions of state, `op`, `mem_ready` and `branch_taken` (Moore/Mealy mix). Any output not named for a state is 0.
- `alu_a_sel` = 1 only for AUIPC (0010111).
- `alu_b_sel` = 0 only for OP (0110011) and BRANCH (1100011); 1 for every other opcode.
- `wb_sel` by opcode: LUI → 11, LOAD → 01, JAL/JALR → 10, all others → 00.
- IDLE: no outputs asserted. Go to FETCH.
- FETCH: `mem_req`=1, `mem_is_fetch`=1.
  - If `mem_ready`: `ir_we`=1 in the same cycle; go to DECODE.
- DECODE: wait one cycle for the decoder to settle.
  - If `unknown_instr`: go to TRAP with cause 01.
  - Else: go to EXEC.
- EXEC:
  - LOAD or STORE: go to MEM.
  - BRANCH: `pc_we`=1, `pc_src` = `branch_taken` ? 01 : 00, `instret`=1; go to FETCH.
  - All others (LUI, AUIPC, JAL, JALR, OP-IMM, OP): go to WB.
- MEM: `mem_req`=1, `mem_is_fetch`=0, `mem_we` = (op == STORE).
  - On `mem_ready` with STORE: `pc_we`=1, `pc_src`=00, `instret`=1; go to FETCH.
  - On `mem_ready` with LOAD: go to WB.
- WB: `rf_we`=1, `pc_we`=1, `instret`=1; go to FETCH.
  - `pc_src` = 01 for JAL, 10 for JALR, 00 otherwise.
  - The register file and PC update on the same edge, so rd receives the old PC+4.
- TRAP: `trap`=1 and `trap_cause` held; no enables asserted. Only reset exits TRAP.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle `mem_req`=1 and `mem_ready`=0.
  - Width is $clog2(MEM_TIMEOUT+1).
  - If `mem_ready` is still low in the MEM_TIMEOUT-th waiting cycle: go to TRAP with cause 10.
  - `mem_ready` in that same cycle wins; no trap.
- `trap_cause` is 00 in every state except TRAP.

## Timing
- Reset, asserted at any time and in any state: state is IDLE immediately, without waiting for a clock edge. All outputs are 0, including a dropped `mem_req` mid-transfer. The wait counter is 0.
- First `mem_req` is asserted one cycle after reset deasserts.
- Latency with zero-wait memory (`mem_ready` high in the first request cycle):
  - BRANCH: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Handshake: `mem_req` stays high and the address/we selects stay stable until the cycle `mem_ready`=1. A request transfers in the cycle where `mem_req` and `mem_ready` are both 1.
- `instret` pulses exactly once per instruction, in the cycle `pc_we`=1. `pc_we` is never asserted twice per instruction.

## Test plan
- ADDI (0010011) with zero-wait memory: states 1,2,3,5, then FETCH again. In WB: `rf_we`=1, `wb_sel`=00, `alu_b_sel`=1, `pc_src`=00, `instret`=1.
- Taken BEQ, then not-taken BEQ: each retires from EXEC with `pc_we`=1; `pc_src`=01, then 00. `rf_we` stays 0 throughout.
- LW with `mem_ready` delayed 3 cycles in MEM: `mem_req`=1 and `mem_is_fetch`=0 held for 4 cycles, then WB with `wb_sel`=01; 8 cycles total.
- Timeouts with MEM_TIMEOUT=4:
  - `mem_ready` never rises in FETCH: after 4 waiting cycles, state=7, `trap_cause`=10, `mem_req`=0, held until reset.
  - `mem_ready` in the 4th waiting cycle: no trap.
- `unknown_instr`=1 in DECODE: next state TRAP, `trap_cause`=01, no `pc_we`/`rf_we` pulse.
- Reset asserted mid-MEM for a store: `mem_req` and `mem_we` drop to 0 before the next edge; state=0. After release: IDLE → FETCH.

Source files
------------

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - RV32I multi-cycle sequencing controller
// Fetch/decode/execute/memory/writeback FSM with memory bus timeout and sticky trap.
module core_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       unknown_instr,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       instret,
  output logic [2:0] state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [2:0]    state_d;
  logic [1:0]    cause_q;
  logic [1:0]    cause_d;
  logic [CW-1:0] wait_cnt;
  logic          is_load;
  logic          is_store;
  logic          is_branch;
  logic          wait_expired;
  logic          sel_a;
  logic          sel_b;

  assign is_load   = (op == OPC_LOAD);
  assign is_store  = (op == OPC_STORE);
  assign is_branch = (op == OPC_BRANCH);
  assign sel_a     = (op == OPC_AUIPC);
  assign sel_b     = !((op == OPC_OP) || is_branch);

  // Last permitted waiting cycle of a request; mem_ready in it still completes the transfer.
  assign wait_expired = (wait_cnt == CW'(MEM_TIMEOUT - 1)) && !mem_ready;

  assign trap_cause = (state == S_TRAP) ? cause_q : 2'b00;

  always_comb begin
    state_d      = state;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    trap         = 1'b0;
    instret      = 1'b0;
    case (state)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        alu_a_sel = sel_a;
        alu_b_sel = sel_b;
        if (unknown_instr) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a_sel = sel_a;
        alu_b_sel = sel_b;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? 2'b01 : 2'b00;
          instret = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_a_sel = sel_a;
        alu_b_sel = sel_b;
        mem_req   = 1'b1;
        mem_we    = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            instret = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        alu_a_sel = sel_a;
        alu_b_sel = sel_b;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        instret   = 1'b1;
        state_d   = S_FETCH;
        case (op)
          OPC_LUI:  wb_sel = 2'b11;
          OPC_LOAD: wb_sel = 2'b01;
          OPC_JAL:  begin wb_sel = 2'b10; pc_src = 2'b01; end
          OPC_JALR: begin wb_sel = 2'b10; pc_src = 2'b10; end
          default:  wb_sel = 2'b00;
        endcase
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cause_q  <= 2'b00;
      wait_cnt <= '0;
    end else begin
      state   <= state_d;
      cause_q <= cause_d;
      // A state change is the only way into FETCH or MEM, so it also restarts the wait count.
      if (state_d != state) begin
        wait_cnt <= '0;
      end else if (mem_req && !mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - self-checking bench for core_ctrl
// Random instruction streams checked against per-instruction rules for latency and control pulses.
module tb_core_ctrl;

  localparam int TMO = 4;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       unknown_instr = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we;
  logic       alu_a_sel, alu_b_sel, trap, instret;
  logic [1:0] pc_src, wb_sel, trap_cause;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int seq[$];

  core_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .op(op), .unknown_instr(unknown_instr),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .trap(trap), .trap_cause(trap_cause),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] all_outs();
    return {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_src, rf_we, wb_sel,
            alu_a_sel, alu_b_sel, trap, trap_cause, instret};
  endfunction

  // Rules from the instruction's class: base latency, register write, PC source, writeback source.
  function automatic int ref_latency(logic [6:0] o, int fw, int mw);
    if (o == BRANCH) return 3 + fw;
    if (o == LOAD) return 5 + fw + mw;
    if (o == STORE) return 4 + fw + mw;
    return 4 + fw;
  endfunction

  function automatic logic [1:0] ref_pc_src(logic [6:0] o, logic tk);
    if (o == BRANCH) return tk ? 2'b01 : 2'b00;
    if (o == JAL) return 2'b01;
    if (o == JALR) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] ref_wb_sel(logic [6:0] o);
    if (o == LUI) return 2'b11;
    if (o == LOAD) return 2'b01;
    if (o == JAL || o == JALR) return 2'b10;
    return 2'b00;
  endfunction

  // Assert reset for a cycle and release it; leaves the DUT in its first FETCH cycle.
  task automatic restart();
    reset = 1'b1;
    mem_ready = 1'b0;
    unknown_instr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one instruction starting in FETCH; fw/mw are wait cycles before mem_ready.
  task automatic exec_instr(input logic [6:0] o, input logic tk, input int fw, input int mw);
    int cyc = 0, freq = 0, mreq = 0, n_ir = 0, n_pc = 0, n_ret = 0, n_rf = 0, bad_we = 0, bad_pair = 0;
    logic [1:0] got_src = 2'bxx, got_wb = 2'bxx;
    logic got_a = 1'bx, got_b = 1'bx;
    logic is_st, done;
    is_st = (o == STORE);
    done = 1'b0;
    op = o; branch_taken = tk; unknown_instr = 1'b0;
    seq.delete();
    while (!done && cyc < 40) begin
      mem_ready = 1'b0;
      if (mem_req) begin
        if (mem_is_fetch) begin
          mem_ready = (freq == fw); freq++;
        end else begin
          mem_ready = (mreq == mw); mreq++;
          if (mem_we !== is_st) bad_we++;
        end
      end
      #1;
      seq.push_back(int'(state));
      cyc++;
      if (ir_we) n_ir++;
      if (pc_we) n_pc++;
      if (pc_we !== instret) bad_pair++;
      if (rf_we) begin n_rf++; got_wb = wb_sel; got_a = alu_a_sel; got_b = alu_b_sel; end
      if (instret) begin n_ret++; got_src = pc_src; done = 1'b1; end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    tests++; if (!done) begin fails++; $display("FAIL retire_budget op=%b got no retire in 40 cycles", o); end
    tests++; if (cyc !== ref_latency(o, fw, mw)) begin fails++; $display("FAIL latency op=%b fw=%0d mw=%0d got %0d exp %0d", o, fw, mw, cyc, ref_latency(o, fw, mw)); end
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL next_fetch op=%b got state %0d exp 1", o, state); end
    tests++; if (n_ir !== 1 || freq !== fw + 1) begin fails++; $display("FAIL fetch op=%b got ir_we %0d req %0d exp 1 %0d", o, n_ir, freq, fw + 1); end
    tests++; if (n_pc !== 1 || n_ret !== 1 || bad_pair !== 0) begin fails++; $display("FAIL retire op=%b got pc_we %0d instret %0d unpaired %0d exp 1 1 0", o, n_pc, n_ret, bad_pair); end
    tests++; if (got_src !== ref_pc_src(o, tk)) begin fails++; $display("FAIL pc_src op=%b tk=%b got %b exp %b", o, tk, got_src, ref_pc_src(o, tk)); end
    if (o == LOAD || o == STORE) begin
      tests++; if (mreq !== mw + 1 || bad_we !== 0) begin fails++; $display("FAIL mem_phase op=%b got req %0d bad_we %0d exp %0d 0", o, mreq, bad_we, mw + 1); end
    end
    if (o == BRANCH || o == STORE) begin
      tests++; if (n_rf !== 0) begin fails++; $display("FAIL rf_we_none op=%b got %0d exp 0", o, n_rf); end
    end else begin
      tests++; if (n_rf !== 1) begin fails++; $display("FAIL rf_we_once op=%b got %0d exp 1", o, n_rf); end
      tests++; if (got_wb !== ref_wb_sel(o)) begin fails++; $display("FAIL wb_sel op=%b got %b exp %b", o, got_wb, ref_wb_sel(o)); end
      tests++; if ({got_a, got_b} !== {o == AUIPC, !(o == OPR)}) begin fails++; $display("FAIL alu_sel op=%b got %b%b exp %b%b", o, got_a, got_b, o == AUIPC, !(o == OPR)); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    tests++; if (state !== 3'd0 || all_outs() !== 18'd0) begin fails++; $display("FAIL reset_outs got state %0d outs %h exp 0 0", state, all_outs()); end
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (state !== 3'd0 || mem_req !== 1'b0) begin fails++; $display("FAIL reset_idle got state %0d req %b exp 0 0", state, mem_req); end
    @(posedge clk); #1;
    tests++; if (state !== 3'd1 || mem_req !== 1'b1 || mem_is_fetch !== 1'b1) begin fails++; $display("FAIL first_fetch got state %0d req %b fetch %b exp 1 1 1", state, mem_req, mem_is_fetch); end
  endtask

  task automatic test_addi();
    exec_instr(OPIMM, 1'b0, 0, 0);
    tests++; if (seq.size() !== 4 || seq[0] !== 1 || seq[1] !== 2 || seq[2] !== 3 || seq[3] !== 5) begin
      fails++; $display("FAIL addi_states got %p exp '{1,2,3,5}", seq);
    end
  endtask

  task automatic test_branch();
    exec_instr(BRANCH, 1'b1, 0, 0);
    exec_instr(BRANCH, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    exec_instr(LOAD, 1'b0, 0, 3);
    tests++; if (seq.size() !== 8 || seq[3] !== 4 || seq[6] !== 4 || seq[7] !== 5) begin
      fails++; $display("FAIL lw_states got %p exp '{1,2,3,4,4,4,4,5}", seq);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR};
    for (int i = 0; i < 40; i++) begin
      exec_instr(ops[$urandom_range(0, 8)], 1'($urandom), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
    end
  endtask

  task automatic test_fetch_timeout();
    int bad = 0;
    restart();
    mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (state !== 3'd1 || mem_req !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL tmo_wait got %0d bad waiting cycles exp 0", bad); end
    tests++; if (state !== 3'd7 || trap_cause !== 2'b10 || trap !== 1'b1 || mem_req !== 1'b0) begin
      fails++; $display("FAIL tmo_trap got state %0d cause %b trap %b req %b exp 7 10 1 0", state, trap_cause, trap, mem_req);
    end
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    tests++; if (state !== 3'd7 || trap_cause !== 2'b10 || pc_we !== 1'b0) begin fails++; $display("FAIL tmo_sticky got state %0d cause %b exp 7 10", state, trap_cause); end
    restart();
    tests++; if (state !== 3'd1 || trap_cause !== 2'b00 || trap !== 1'b0) begin fails++; $display("FAIL tmo_reset got state %0d cause %b exp 1 00", state, trap_cause); end
  endtask

  task automatic test_ready_last_cycle();
    exec_instr(STORE, 1'b0, TMO - 1, TMO - 1);
    exec_instr(LOAD, 1'b0, TMO - 1, TMO - 1);
  endtask

  task automatic test_unknown();
    op = 7'b1111111;
    unknown_instr = 1'b1;
    mem_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    tests++; if (state !== 3'd2 || pc_we !== 1'b0 || rf_we !== 1'b0) begin fails++; $display("FAIL ill_decode got state %0d pc_we %b rf_we %b exp 2 0 0", state, pc_we, rf_we); end
    @(posedge clk); #1;
    tests++; if (state !== 3'd7 || trap_cause !== 2'b01 || pc_we !== 1'b0 || rf_we !== 1'b0 || instret !== 1'b0) begin
      fails++; $display("FAIL ill_trap got state %0d cause %b pc_we %b rf_we %b exp 7 01 0 0", state, trap_cause, pc_we, rf_we);
    end
    restart();
  endtask

  task automatic test_reset_mid_store();
    op = STORE;
    unknown_instr = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (state !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_is_fetch !== 1'b0) begin
      fails++; $display("FAIL store_mem got state %0d req %b we %b exp 4 1 1", state, mem_req, mem_we);
    end
    #2 reset = 1'b1;
    #1;
    tests++; if (state !== 3'd0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL async_reset got state %0d req %b we %b exp 0 0 0", state, mem_req, mem_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL rst_idle got state %0d exp 0", state); end
    @(posedge clk); #1;
    tests++; if (state !== 3'd1 || mem_req !== 1'b1) begin fails++; $display("FAIL rst_fetch got state %0d req %b exp 1 1", state, mem_req); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_lw_wait();
    test_random();
    test_fetch_timeout();
    test_ready_last_cycle();
    test_unknown();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
